rf_dump_reader: RTL and testbench

Debug read-out engine for the CPU register file. On command, it walks register addresses 0..NREGS-1 through one spare asynchronous read port. Each word is registered and streamed to a downstream consumer (UART/seven-segment display driver) over a valid/ready handshake. It sits beside the datapath and is read-only: it never drives the register-file write port.

---
 rtl/rf_dump_reader_if.sv | 24 ++
 rtl/rf_dump_reader.sv | 85 ++++++++
 tb/tb_rf_dump_reader.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/rf_dump_reader_if.sv
// rf_dump_reader_if: control, register-file read port and output stream of the dump engine
interface rf_dump_reader_if #(
  parameter int AW = 5,
  parameter int DW = 32
);
  logic          Start;
  logic          Abort;
  logic [AW-1:0] RAddr;
  logic [DW-1:0] RData;
  logic          OutValid;
  logic          OutReady;
  logic [DW-1:0] OutData;
  logic [AW-1:0] OutIdx;
  logic          Busy;
  logic          Done;
  modport master (
    input  Start, Abort, RData, OutReady,
    output RAddr, OutValid, OutData, OutIdx, Busy, Done
  );
  modport slave (
    output Start, Abort, RData, OutReady,
    input  RAddr, OutValid, OutData, OutIdx, Busy, Done
  );
endinterface

// File: rtl/rf_dump_reader.sv
// rf_dump_reader: walks the register file through a spare read port and streams each word out
module rf_dump_reader #(
  parameter int NREGS = 32,
  parameter int AW    = 5,
  parameter int DW    = 32
) (
  input logic             Clk,
  input logic             Reset,
  rf_dump_reader_if.master bus
);
  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] CAPTURE = 2'd1;
  localparam logic [1:0] SEND    = 2'd2;
  localparam logic [1:0] FIN     = 2'd3;
  localparam logic [AW-1:0] LAST = AW'(NREGS - 1);
  logic [1:0]    state_q, state_d;
  logic [AW-1:0] idx_q, idx_d;
  logic [AW-1:0] out_idx_q, out_idx_d;
  logic [DW-1:0] out_data_q, out_data_d;
  logic          out_valid_q, out_valid_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  // next-state logic; Abort during an active dump overrides whatever the state decided
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    out_idx_d   = out_idx_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    case (state_q)
      IDLE: if (!bus.Abort && bus.Start) begin
        idx_d   = '0;
        state_d = CAPTURE;
      end
      CAPTURE: begin
        out_data_d  = bus.RData;
        out_idx_d   = idx_q;
        out_valid_d = 1'b1;
        state_d     = SEND;
      end
      SEND: if (out_valid_q && bus.OutReady) begin
        out_valid_d = 1'b0;
        state_d     = (idx_q == LAST) ? FIN : CAPTURE;
        idx_d       = (idx_q == LAST) ? idx_q : idx_q + AW'(1);
      end
      default: begin
        idx_d   = '0;
        state_d = IDLE;
      end
    endcase
    if (bus.Abort && (state_q == CAPTURE || state_q == SEND)) begin
      state_d     = IDLE;
      out_valid_d = 1'b0;
      idx_d       = '0;
    end
    busy_d = (state_d == CAPTURE) || (state_d == SEND);
    done_d = (state_d == FIN);
  end
  // state and output registers; Busy/Done are registered from the next state
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      out_idx_q   <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      out_idx_q   <= out_idx_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end
  assign bus.RAddr    = idx_q;
  assign bus.OutValid = out_valid_q;
  assign bus.OutData  = out_data_q;
  assign bus.OutIdx   = out_idx_q;
  assign bus.Busy     = busy_q;
  assign bus.Done     = done_q;
endmodule

// File: tb/tb_rf_dump_reader.sv
// tb_rf_dump_reader: directed checks of the register-file dump engine
module tb_rf_dump_reader;
  logic Clk = 1'b0;
  logic Reset;
  always #5 Clk = ~Clk;
  rf_dump_reader_if #(.AW(5), .DW(32)) bus ();
  rf_dump_reader #(.NREGS(32), .AW(5), .DW(32)) dut (.Clk(Clk), .Reset(Reset), .bus(bus));
  logic [31:0] rf  [32];
  logic [31:0] exp_d [32];
  logic [31:0] got [32];
  assign bus.RData = rf[bus.RAddr];
  int tests = 0;
  int fails = 0;
  int n, cyc, dones, done_cyc, first_valid, stall;
  logic [4:0] abort_seen_idx;

  task tick;
    @(posedge Clk);
    #1;
  endtask

  task preload;
    for (int i = 0; i < 32; i++) begin
      rf[i]    = 32'(i) * 32'h11111111;
      exp_d[i] = 32'(i) * 32'h11111111;
      got[i]   = 32'hx;
    end
    n = 0; cyc = 0; dones = 0; done_cyc = -1; first_valid = -1; stall = 0;
  endtask

  task record;
    if (bus.OutValid && bus.OutReady) begin
      tests++;
      if (bus.OutIdx !== 5'(n) || bus.OutData !== exp_d[n]) begin
        fails++;
        $display("FAIL word_%0d: got idx %0d data %h, want idx %0d data %h", n, bus.OutIdx, bus.OutData, n, exp_d[n]);
      end
      if (n < 32) got[n] = bus.OutData;
      n++;
    end
    if (bus.Done) begin
      dones++;
      if (done_cyc < 0) done_cyc = cyc;
    end
  endtask

  task test_reset;
    Reset = 1'b1; bus.Start = 1'b0; bus.Abort = 1'b0; bus.OutReady = 1'b0;
    tick; tick;
    Reset = 1'b0;
    tests++; if (bus.RAddr !== 5'd0) begin fails++; $display("FAIL reset_raddr: got %0d want 0", bus.RAddr); end
    tests++; if (bus.OutValid !== 1'b0) begin fails++; $display("FAIL reset_valid: got %b want 0", bus.OutValid); end
    tests++; if (bus.OutData !== 32'd0) begin fails++; $display("FAIL reset_data: got %h want 0", bus.OutData); end
    tests++; if (bus.OutIdx !== 5'd0) begin fails++; $display("FAIL reset_idx: got %0d want 0", bus.OutIdx); end
    tests++; if (bus.Busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b want 0", bus.Busy); end
    tests++; if (bus.Done !== 1'b0) begin fails++; $display("FAIL reset_done: got %b want 0", bus.Done); end
  endtask

  task test_full_dump;
    preload;
    bus.OutReady = 1'b1;
    bus.Start = 1'b1;
    for (int c = 0; c < 72; c++) begin
      tick; cyc++;
      bus.Start = 1'b0;
      if (bus.OutValid && first_valid < 0) first_valid = cyc;
      record;
    end
    tests++; if (n !== 32) begin fails++; $display("FAIL full_count: got %0d want 32", n); end
    tests++; if (first_valid !== 2) begin fails++; $display("FAIL full_latency: got %0d want 2", first_valid); end
    tests++; if (done_cyc !== 65) begin fails++; $display("FAIL full_done_cycle: got %0d want 65", done_cyc); end
    tests++; if (dones !== 1) begin fails++; $display("FAIL full_done_count: got %0d want 1", dones); end
    tests++; if (got[5] !== 32'h55555555) begin fails++; $display("FAIL full_word5: got %h want 55555555", got[5]); end
    tests++; if (got[0] !== 32'h0) begin fails++; $display("FAIL full_word0: got %h want 0", got[0]); end
    tests++; if (bus.Busy !== 1'b0) begin fails++; $display("FAIL full_busy_after: got %b want 0", bus.Busy); end
  endtask

  task test_backpressure;
    preload;
    bus.OutReady = 1'b1;
    bus.Start = 1'b1;
    for (int c = 0; c < 90; c++) begin
      tick; cyc++;
      bus.Start = 1'b0;
      if (bus.OutValid && bus.OutIdx == 5'd3 && stall < 10) begin
        bus.OutReady = 1'b0;
        stall++;
        tests++;
        if (bus.OutData !== 32'h33333333 || bus.OutIdx !== 5'd3 || bus.OutValid !== 1'b1) begin
          fails++;
          $display("FAIL stall_hold_%0d: got v %b idx %0d data %h, want v 1 idx 3 data 33333333", stall, bus.OutValid, bus.OutIdx, bus.OutData);
        end
      end else bus.OutReady = 1'b1;
      record;
    end
    tests++; if (stall !== 10) begin fails++; $display("FAIL stall_cycles: got %0d want 10", stall); end
    tests++; if (n !== 32) begin fails++; $display("FAIL stall_count: got %0d want 32", n); end
    tests++; if (done_cyc !== 75 || dones !== 1) begin fails++; $display("FAIL stall_done: got cycle %0d count %0d want cycle 75 count 1", done_cyc, dones); end
  endtask

  task test_abort;
    preload;
    bus.OutReady = 1'b1;
    bus.Start = 1'b1;
    abort_seen_idx = 5'd0;
    for (int c = 0; c < 40 && bus.Abort !== 1'b1; c++) begin
      tick; cyc++;
      bus.Start = 1'b0;
      if (bus.OutValid && bus.OutIdx == 5'd7) begin
        bus.OutReady = 1'b0;
        bus.Abort = 1'b1;
        abort_seen_idx = bus.OutIdx;
      end
      record;
    end
    tests++; if (bus.Abort !== 1'b1 || abort_seen_idx !== 5'd7) begin fails++; $display("FAIL abort_reach: got abort %b idx %0d want 1 7", bus.Abort, abort_seen_idx); end
    tick;
    bus.Abort = 1'b0;
    tests++; if (bus.OutValid !== 1'b0) begin fails++; $display("FAIL abort_valid: got %b want 0", bus.OutValid); end
    tests++; if (bus.Busy !== 1'b0) begin fails++; $display("FAIL abort_busy: got %b want 0", bus.Busy); end
    tests++; if (bus.RAddr !== 5'd0) begin fails++; $display("FAIL abort_raddr: got %0d want 0", bus.RAddr); end
    for (int c = 0; c < 4; c++) begin
      if (bus.Done) dones++;
      tick;
    end
    tests++; if (dones !== 0 || n !== 7) begin fails++; $display("FAIL abort_no_done: got done %0d words %0d want 0 7", dones, n); end
    bus.OutReady = 1'b1;
    bus.Start = 1'b1;
    tick;
    bus.Start = 1'b0;
    for (int c = 0; c < 5 && !bus.OutValid; c++) tick;
    tests++; if (bus.OutValid !== 1'b1 || bus.OutIdx !== 5'd0 || bus.OutData !== 32'd0) begin fails++; $display("FAIL abort_restart: got v %b idx %0d data %h want 1 0 0", bus.OutValid, bus.OutIdx, bus.OutData); end
    bus.Abort = 1'b1;
    tick;
    bus.Abort = 1'b0;
    tick;
  endtask

  task test_concurrent_write;
    preload;
    exp_d[20] = 32'hDEADBEEF;
    bus.OutReady = 1'b1;
    bus.Start = 1'b1;
    for (int c = 0; c < 70; c++) begin
      tick; cyc++;
      bus.Start = 1'b0;
      if (bus.OutValid && bus.OutIdx == 5'd10) rf[20] = 32'hDEADBEEF;
      if (bus.OutValid && bus.OutIdx == 5'd4) rf[4] = 32'h00001234;
      record;
    end
    tests++; if (got[20] !== 32'hDEADBEEF) begin fails++; $display("FAIL snap_word20: got %h want deadbeef", got[20]); end
    tests++; if (got[4] !== 32'h44444444) begin fails++; $display("FAIL snap_word4: got %h want 44444444", got[4]); end
    tests++; if (n !== 32 || dones !== 1) begin fails++; $display("FAIL snap_count: got %0d words %0d done want 32 1", n, dones); end
  endtask

  task test_start_ignored;
    preload;
    bus.OutReady = 1'b1;
    bus.Start = 1'b1;
    for (int c = 0; c < 75; c++) begin
      tick; cyc++;
      bus.Start = (cyc == 10 || cyc == 31 || cyc == 64) ? 1'b1 : 1'b0;
      record;
    end
    bus.Start = 1'b0;
    tests++; if (n !== 32 || dones !== 1 || done_cyc !== 65) begin fails++; $display("FAIL busy_start: got %0d words %0d done at %0d want 32 1 65", n, dones, done_cyc); end
    bus.Start = 1'b1;
    bus.Abort = 1'b1;
    tick;
    bus.Start = 1'b0;
    bus.Abort = 1'b0;
    tick;
    tests++; if (bus.Busy !== 1'b0 || bus.OutValid !== 1'b0) begin fails++; $display("FAIL start_abort_idle: got busy %b valid %b want 0 0", bus.Busy, bus.OutValid); end
  endtask

  task test_reset_mid;
    preload;
    bus.OutReady = 1'b1;
    bus.Start = 1'b1;
    for (int c = 0; c < 40 && Reset !== 1'b1; c++) begin
      tick; cyc++;
      bus.Start = 1'b0;
      if (bus.OutValid && bus.OutIdx == 5'd15) Reset = 1'b1;
    end
    tests++; if (Reset !== 1'b1) begin fails++; $display("FAIL midreset_reach: word 15 never seen"); end
    tick;
    Reset = 1'b0;
    tests++; if (bus.OutValid !== 1'b0 || bus.Busy !== 1'b0 || bus.Done !== 1'b0) begin fails++; $display("FAIL midreset_ctrl: got v %b busy %b done %b want 0 0 0", bus.OutValid, bus.Busy, bus.Done); end
    tests++; if (bus.RAddr !== 5'd0 || bus.OutIdx !== 5'd0 || bus.OutData !== 32'd0) begin fails++; $display("FAIL midreset_data: got raddr %0d idx %0d data %h want 0 0 0", bus.RAddr, bus.OutIdx, bus.OutData); end
    tick;
    tests++; if (bus.Busy !== 1'b0 || bus.OutValid !== 1'b0) begin fails++; $display("FAIL midreset_idle: got busy %b valid %b want 0 0", bus.Busy, bus.OutValid); end
  endtask

  initial begin
    test_reset;
    test_full_dump;
    test_backpressure;
    test_abort;
    test_concurrent_write;
    test_start_ignored;
    test_reset_mid;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
